frame_write_ctrl: RTL

//  Sequences camera frames into the frame_buffer write port (port A) in the OV7725 PCLK domain.
//  - Waits for sensor configuration and discards settling frames.
//  - Pairs bytes into RGB565 and generates addr/we for each pixel.
//  - Supports continuous capture or single-shot snapshot.
//  - Sits between the OV7725 pins and frame_buffer; replaces an always-write capture path.

---
 rtl/frame_write_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/frame_write_ctrl.sv
// frame_write_ctrl: sequences OV7725 frames into the frame_buffer write port.
// Waits for sensor configuration and discards settling frames. Pairs bytes
// into RGB565 pixels and generates addr/we for each pixel. Supports continuous
// capture or single-shot snapshots.
module frame_write_ctrl #(
  parameter int H_PIX       = 320,
  parameter int V_LINES     = 240,
  parameter int ADDR_W      = 17,
  parameter int SKIP_FRAMES = 2
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              cfg_done,
  input  logic              mode_cont,
  input  logic              snap_req,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        d,
  output logic [ADDR_W-1:0] addr,
  output logic [15:0]       dout,
  output logic              we,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow,
  output logic [7:0]        frame_cnt
);

  typedef enum logic [2:0] {IDLE, SKIP, ARMED, CAPTURE, DONE} state_t;

  // Counters carry one spare bit so they can run past the limits and saturate
  localparam int COL_W  = $clog2(H_PIX + 1) + 1;
  localparam int LINE_W = $clog2(V_LINES + 1) + 1;
  localparam logic [COL_W-1:0]  COL_LIM   = COL_W'(H_PIX);
  localparam logic [LINE_W-1:0] LINE_LIM  = LINE_W'(V_LINES);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_PIX);
  localparam logic [7:0]        SKIP_LAST = (SKIP_FRAMES == 0) ? 8'd0 : 8'(SKIP_FRAMES - 1);

  state_t state, next_state;

  logic              s_vsync, s_vsync_d, s_href, s_href_d;
  logic [7:0]        s_d;
  logic [7:0]        skip_cnt;
  logic              snap_pend;
  logic              phase;
  logic [7:0]        hi;
  logic [COL_W-1:0]  col;
  logic [LINE_W-1:0] line;
  logic [ADDR_W-1:0] line_base;
  logic              pix_we;
  logic [ADDR_W-1:0] pix_addr;
  logic [15:0]       pix_data;

  logic fs, fe, line_end, capturing, pix_strobe, in_range, cap_start;

  assign fs         = s_vsync_d & ~s_vsync;
  assign fe         = ~s_vsync_d & s_vsync;
  assign line_end   = s_href_d & ~s_href;
  assign capturing  = (state == CAPTURE);
  assign pix_strobe = capturing & s_href & phase;
  assign in_range   = (col < COL_LIM) && (line < LINE_LIM);
  assign cap_start  = (state == ARMED) && (next_state == CAPTURE);
  assign busy       = capturing;
  assign frame_done = (state == DONE);

  // Register the camera pins once and keep a delayed copy for edge detection
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      s_vsync   <= 1'b0;
      s_vsync_d <= 1'b0;
      s_href    <= 1'b0;
      s_href_d  <= 1'b0;
      s_d       <= 8'd0;
    end else begin
      s_vsync   <= vsync;
      s_vsync_d <= s_vsync;
      s_href    <= href;
      s_href_d  <= s_href;
      s_d       <= d;
    end
  end

  // State register
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic; losing sensor configuration abandons everything
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (cfg_done) next_state = SKIP;
      SKIP:    if (SKIP_FRAMES == 0 || (fe && skip_cnt == SKIP_LAST)) next_state = ARMED;
      ARMED:   if (fs && (mode_cont || snap_pend)) next_state = CAPTURE;
      CAPTURE: if (fe) next_state = DONE;
      DONE:    next_state = ARMED;
      default: next_state = IDLE;
    endcase
    if (!cfg_done) next_state = IDLE;
  end

  // Settling-frame counter, snapshot request latch and captured-frame count
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      skip_cnt  <= 8'd0;
      snap_pend <= 1'b0;
      frame_cnt <= 8'd0;
    end else begin
      if (state == SKIP) begin
        if (fe) skip_cnt <= skip_cnt + 8'd1;
      end else begin
        skip_cnt <= 8'd0;
      end
      if (state == IDLE || cap_start) snap_pend <= 1'b0;
      else if (snap_req)              snap_pend <= 1'b1;
      if (state == DONE) frame_cnt <= frame_cnt + 8'd1;
    end
  end

  // Byte pairing, line/column tracking and per-pixel write decision
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      phase     <= 1'b0;
      hi        <= 8'd0;
      col       <= '0;
      line      <= '0;
      line_base <= '0;
      overflow  <= 1'b0;
      pix_we    <= 1'b0;
      pix_addr  <= '0;
      pix_data  <= 16'd0;
    end else begin
      if (!capturing || !s_href) phase <= 1'b0;
      else                       phase <= ~phase;
      if (capturing && s_href && !phase) hi <= s_d;
      pix_we <= 1'b0;
      if (cap_start) begin
        col       <= '0;
        line      <= '0;
        line_base <= '0;
        overflow  <= 1'b0;
      end else if (capturing) begin
        if (pix_strobe) begin
          pix_addr <= line_base + ADDR_W'(col);
          pix_data <= {hi, s_d};
          pix_we   <= in_range & cfg_done;
          if (!in_range) overflow <= 1'b1;
          if (col != '1) col <= col + 1'b1;
        end else if (line_end && col != '0) begin
          line_base <= line_base + LINE_STEP;
          if (line != '1) line <= line + 1'b1;
          col <= '0;
        end
      end
    end
  end

  // Registered write port; addr/dout hold their last value between writes
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      we   <= 1'b0;
      addr <= '0;
      dout <= 16'd0;
    end else if (pix_we && capturing) begin
      we   <= 1'b1;
      addr <= pix_addr;
      dout <= pix_data;
    end else begin
      we   <= 1'b0;
    end
  end

endmodule
